tail_light_pattern_monitor: RTL
===============================

// Module: tail_light_pattern_monitor
// PURPOSE
//  Receive-side decoder for the 3-bit tail-light control buses driven by the Mustang tail-light controller.
//  Watches both sides and recovers the active mode per side: OFF, TURN, BRAKE or BRAKE_TURN.
//  Flags illegal pattern transitions with a sticky fault bit.
//  Sits next to the controller on the lamp-driver side, for diagnostics and self-check.
// PARAMETERS
//  IDLE_CYCLES    8   consecutive sampled 000 cycles before mode falls to OFF
//  STEADY_CYCLES  8   consecutive sampled 111 cycles (state HOLD) before mode = BRAKE
//  SEQ_TIMEOUT    4   max cycles in one sequence state (needs TLC_MON_TIMEOUT_EN)
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      async active-low reset
//  right_tl      in   [0:2]  right tail-light control bus, literal 3'bxyz = bits 0,1,2
//  left_tl       in   [0:2]  left tail-light control bus, same encoding
//  fault_clr     in   1      clears both sticky fault flags
//  right_mode    out  [1:0]  00 OFF, 01 TURN, 10 BRAKE, 11 BRAKE_TURN
//  left_mode     out  [1:0]  same encoding as right_mode
//  right_seq_done out 1      1-cycle pulse when a full right sequence completes
//  left_seq_done  out 1      1-cycle pulse when a full left sequence completes
//  right_fault   out  1      sticky: illegal right transition or timeout
//  left_fault    out  1      sticky: illegal left transition or timeout
// BEHAVIOUR
//  - Reset: all outputs 0, input sample regs 000, FSMs IDLE, all counters 0. Async assert, sync use.
//  - Inputs are registered once; the FSMs act on the sampled value. Every output responds 2 clk edges after a pattern appears at the port.
//  - Two identical, independent per-side FSMs. Next state is chosen from the sampled pattern:
//    IDLE: 000 stay | 001 -> T1 | 111 -> HOLD | other -> FLT
//    T1:   001 stay | 011 -> T2 | other -> FLT
//    T2:   011 stay | 111 -> T3 | other -> FLT
//    T3:   111 stay | 000 -> IDLE, pulse seq_done, mode=TURN | other -> FLT
//    HOLD: 111 stay | 110 -> B1 | 000 -> IDLE | other -> FLT
//    B1:   110 stay | 100 -> B2 | other -> FLT
//    B2:   100 stay | 000 -> IDLE, pulse seq_done, mode=BRAKE_TURN | other -> FLT
//    FLT:  000 -> IDLE | else stay
//  - Entering FLT sets the side's fault flag. Mode holds its prior value.
//  - idle_cnt: counts consecutive cycles in IDLE, saturating. Cleared on leaving IDLE.
//    When it reaches IDLE_CYCLES, mode = OFF.
//    The 2-cycle 000 gap inside a turn sequence therefore never drops the mode.
//  - hold_cnt: counts consecutive cycles in HOLD, saturating. When it reaches STEADY_CYCLES, mode = BRAKE.
//  - Counter width = $clog2(max param + 1). Counters never wrap.
//  - fault_clr clears both flags. If fault_clr and a new fault land in the same cycle, set wins (flag stays 1).
//  - Reset mid-sequence returns to IDLE with no seq_done pulse.
// CONFIGURATION
//  TLC_MON_TIMEOUT_EN defined:
//    - per-side seq_cnt counts cycles in T1, T2, T3, B1 and B2; resets on every state change.
//    - on the (SEQ_TIMEOUT+1)th consecutive cycle in one state: -> FLT, fault set.
//  TLC_MON_TIMEOUT_EN undefined:
//    - no seq_cnt logic; sequence states may be held indefinitely; SEQ_TIMEOUT is ignored.
// TESTING
//  1 Reset mid-traffic with rst_n low -> all six outputs 0 asynchronously; IDLE after release.
//  2 right_tl 001,011,111,000,000 twice, left_tl 000
//    -> right_seq_done pulses 2 clks after each 111->000; right_mode=01; left_mode stays 00.
//  3 both buses 111 for 10 cycles from IDLE -> both modes 10 at clk 9 (8 in HOLD + 2 latency - 1).
//  4 left_tl 111,110,100,000,000 -> left_mode=11, one left_seq_done pulse, left_fault=0.
//  5 right_tl 001 then 110 -> right_fault=1 2 clks later; held until fault_clr.
//    Then 000 -> IDLE. fault_clr asserted with a new illegal step in the same cycle -> flag stays 1.
//  6 With TLC_MON_TIMEOUT_EN, SEQ_TIMEOUT=4: right_tl 001 then 011 held 6 cycles
//    -> right_fault=1 after 5th cycle in T2. Same stimulus without the macro -> right_fault stays 0.

Source files
------------

// File: rtl/tail_light_pattern_monitor.sv
// Receive-side decoder for the Mustang tail-light buses: recovers per-side mode, sequence-done pulses and sticky faults.
// Optional per-state sequence timeout is enabled by defining TLC_MON_TIMEOUT_EN.

module tail_light_side_fsm #(
   parameter int unsigned IDLE_CYCLES   = 8,
   parameter int unsigned STEADY_CYCLES = 8,
   parameter int unsigned SEQ_TIMEOUT   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [0:2] tl,
   input  logic       fault_clr,
   output logic [1:0] mode,
   output logic       seq_done,
   output logic       fault
);

   localparam int unsigned MAX_AB = (IDLE_CYCLES > STEADY_CYCLES) ? IDLE_CYCLES : STEADY_CYCLES;
   localparam int unsigned MAX_P  = (MAX_AB > SEQ_TIMEOUT) ? MAX_AB : SEQ_TIMEOUT;
   localparam int unsigned CNT_W  = $clog2(MAX_P + 1);

   localparam logic [1:0] MODE_OFF        = 2'b00;
   localparam logic [1:0] MODE_TURN       = 2'b01;
   localparam logic [1:0] MODE_BRAKE      = 2'b10;
   localparam logic [1:0] MODE_BRAKE_TURN = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_T1, S_T2, S_T3, S_HOLD, S_B1, S_B2, S_FLT
   } state_e;

   state_e             state_q, state_d;
   logic [0:2]         sample_q;
   logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [1:0]         mode_q, mode_d;
   logic               seq_done_q, seq_done_d;
   logic               fault_q, fault_d;
`ifdef TLC_MON_TIMEOUT_EN
   logic [CNT_W-1:0]   seq_cnt_q, seq_cnt_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_q   <= 3'b000;
         state_q    <= S_IDLE;
         idle_cnt_q <= '0;
         hold_cnt_q <= '0;
         mode_q     <= MODE_OFF;
         seq_done_q <= 1'b0;
         fault_q    <= 1'b0;
`ifdef TLC_MON_TIMEOUT_EN
         seq_cnt_q  <= '0;
`endif
      end else begin
         sample_q   <= tl;
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         mode_q     <= mode_d;
         seq_done_q <= seq_done_d;
         fault_q    <= fault_d;
`ifdef TLC_MON_TIMEOUT_EN
         seq_cnt_q  <= seq_cnt_d;
`endif
      end
   end

   // Next state, counters and registered outputs, all driven by the sampled pattern
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = '0;
      hold_cnt_d = '0;
      mode_d     = mode_q;
      seq_done_d = 1'b0;
`ifdef TLC_MON_TIMEOUT_EN
      seq_cnt_d  = '0;
`endif

      case (state_q)
         S_IDLE: begin
            if (sample_q == 3'b001)      state_d = S_T1;
            else if (sample_q == 3'b111) state_d = S_HOLD;
            else if (sample_q != 3'b000) state_d = S_FLT;
         end
         S_T1: begin
            if (sample_q == 3'b011)      state_d = S_T2;
            else if (sample_q != 3'b001) state_d = S_FLT;
         end
         S_T2: begin
            if (sample_q == 3'b111)      state_d = S_T3;
            else if (sample_q != 3'b011) state_d = S_FLT;
         end
         S_T3: begin
            if (sample_q == 3'b000) begin
               state_d    = S_IDLE;
               seq_done_d = 1'b1;
               mode_d     = MODE_TURN;
            end else if (sample_q != 3'b111) begin
               state_d = S_FLT;
            end
         end
         S_HOLD: begin
            if (sample_q == 3'b110)      state_d = S_B1;
            else if (sample_q == 3'b000) state_d = S_IDLE;
            else if (sample_q != 3'b111) state_d = S_FLT;
         end
         S_B1: begin
            if (sample_q == 3'b100)      state_d = S_B2;
            else if (sample_q != 3'b110) state_d = S_FLT;
         end
         S_B2: begin
            if (sample_q == 3'b000) begin
               state_d    = S_IDLE;
               seq_done_d = 1'b1;
               mode_d     = MODE_BRAKE_TURN;
            end else if (sample_q != 3'b100) begin
               state_d = S_FLT;
            end
         end
         default: begin
            if (sample_q == 3'b000) state_d = S_IDLE;
         end
      endcase

`ifdef TLC_MON_TIMEOUT_EN
      // Dwelling too long in one sequence state is treated as a stuck bus
      if ((state_q inside {S_T1, S_T2, S_T3, S_B1, S_B2}) && (state_d == state_q)) begin
         if (seq_cnt_q >= CNT_W'(SEQ_TIMEOUT)) state_d = S_FLT;
         else                                  seq_cnt_d = seq_cnt_q + CNT_W'(1);
      end
`endif

      if (state_d == S_IDLE) begin
         if (state_q != S_IDLE)                        idle_cnt_d = CNT_W'(1);
         else if (idle_cnt_q < CNT_W'(IDLE_CYCLES))    idle_cnt_d = idle_cnt_q + CNT_W'(1);
         else                                          idle_cnt_d = idle_cnt_q;
         if (state_q == S_IDLE && idle_cnt_d >= CNT_W'(IDLE_CYCLES)) mode_d = MODE_OFF;
      end

      if (state_d == S_HOLD) begin
         if (state_q != S_HOLD)                        hold_cnt_d = CNT_W'(1);
         else if (hold_cnt_q < CNT_W'(STEADY_CYCLES))  hold_cnt_d = hold_cnt_q + CNT_W'(1);
         else                                          hold_cnt_d = hold_cnt_q;
         if (hold_cnt_d >= CNT_W'(STEADY_CYCLES)) mode_d = MODE_BRAKE;
      end

      // A new fault outranks a simultaneous clear
      fault_d = (fault_q & ~fault_clr) | ((state_d == S_FLT) && (state_q != S_FLT));
   end

   assign mode     = mode_q;
   assign seq_done = seq_done_q;
   assign fault    = fault_q;

endmodule

module tail_light_pattern_monitor #(
   parameter int unsigned IDLE_CYCLES   = 8,
   parameter int unsigned STEADY_CYCLES = 8,
   parameter int unsigned SEQ_TIMEOUT   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [0:2] right_tl,
   input  logic [0:2] left_tl,
   input  logic       fault_clr,
   output logic [1:0] right_mode,
   output logic [1:0] left_mode,
   output logic       right_seq_done,
   output logic       left_seq_done,
   output logic       right_fault,
   output logic       left_fault
);

   tail_light_side_fsm #(
      .IDLE_CYCLES  (IDLE_CYCLES),
      .STEADY_CYCLES(STEADY_CYCLES),
      .SEQ_TIMEOUT  (SEQ_TIMEOUT)
   ) u_right (
      .clk      (clk),
      .rst_n    (rst_n),
      .tl       (right_tl),
      .fault_clr(fault_clr),
      .mode     (right_mode),
      .seq_done (right_seq_done),
      .fault    (right_fault)
   );

   tail_light_side_fsm #(
      .IDLE_CYCLES  (IDLE_CYCLES),
      .STEADY_CYCLES(STEADY_CYCLES),
      .SEQ_TIMEOUT  (SEQ_TIMEOUT)
   ) u_left (
      .clk      (clk),
      .rst_n    (rst_n),
      .tl       (left_tl),
      .fault_clr(fault_clr),
      .mode     (left_mode),
      .seq_done (left_seq_done),
      .fault    (left_fault)
   );

endmodule
